// File: rtl/prng_stream.sv
// -----------------------------------------------------------------------------
// prng_stream
//   Keccak-f[200] pseudo-random stream generator. A seed is absorbed into a
//   200-bit state, permuted one round per clock, and the top OUT_W bits are
//   offered as a word. Each delivered word triggers a fresh permutation of the
//   full state, so a single seed yields an unbounded word stream.
//
// Parameters
//   SEED_W    seed width, multiple of 8, 8..192
//   OUT_W     output word width, 1..200
//   NROUNDS   rounds per permutation, 1..18 (RC[0..NROUNDS-1])
//   BYTE_SWAP 1 = seed byte 0 lands in state[199:192]; 0 = seed loaded as given
//
// Ports
//   clk         rising-edge clock
//   rst_b       asynchronous active-low reset
//   seed_valid  seed offered            seed_ready  seed accepted this cycle
//   seed        seed value              seed_en     0 = absorb an all-zero seed
//   out_valid   out_data holds a word   out_ready   consumer takes out_data
//   out_data    state[199 -: OUT_W]
//   busy        permutation running
//   block_cnt   words delivered since the last seed load (saturating)
//   state_dbg   current FSM state (0 IDLE, 1 PERM, 2 HOLD)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Seed side: seed_ready is high in IDLE and HOLD. Output side:
// out_valid is high only in HOLD and out_data is stable until the transfer.
// If a seed is accepted on the same edge as an output transfer, the word
// counts as delivered but the reload wins (state reloaded, block_cnt cleared).
// -----------------------------------------------------------------------------
module prng_stream #(
   parameter int SEED_W    = 96,
   parameter int OUT_W     = 96,
   parameter int NROUNDS   = 18,
   parameter int BYTE_SWAP = 1
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              seed_valid,
   output logic              seed_ready,
   input  logic [SEED_W-1:0] seed,
   input  logic              seed_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              busy,
   output logic [15:0]       block_cnt,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PERM = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Keccak rho offsets reduced mod 8, indexed by lane i = 5y+x.
   localparam int RHO [25] = '{0, 1, 6, 4, 3,
                               4, 4, 6, 7, 4,
                               3, 2, 3, 1, 7,
                               1, 5, 7, 5, 0,
                               2, 2, 5, 0, 6};

   localparam logic [4:0] LAST_RC = 5'(NROUNDS - 1);

   state_t       state;
   logic [199:0] s;
   logic [4:0]   rc;
   logic [199:0] round_out;
   logic [199:0] seed_state;

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] round_const(input logic [4:0] idx);
      case (idx)
         5'd0:  return 8'h01;
         5'd1:  return 8'h82;
         5'd2:  return 8'h8A;
         5'd3:  return 8'h00;
         5'd4:  return 8'h8B;
         5'd5:  return 8'h01;
         5'd6:  return 8'h81;
         5'd7:  return 8'h09;
         5'd8:  return 8'h8A;
         5'd9:  return 8'h88;
         5'd10: return 8'h09;
         5'd11: return 8'h0A;
         5'd12: return 8'h8B;
         5'd13: return 8'h8B;
         5'd14: return 8'h89;
         5'd15: return 8'h03;
         5'd16: return 8'h02;
         5'd17: return 8'h80;
         default: return 8'h00;
      endcase
   endfunction

   // One full round: theta, rho, pi, chi, iota on the lane array.
   function automatic logic [199:0] keccak_round(input logic [199:0] s_in,
                                                 input logic [7:0]   rc_in);
      logic [7:0]   a [25];
      logic [7:0]   b [25];
      logic [7:0]   c [5];
      logic [7:0]   d [5];
      logic [199:0] r;
      r = '0;
      for (int i = 0; i < 25; i++) a[i] = s_in[199 - 8*i -: 8];
      for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
      for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl8(c[(x+1)%5], 1);
      for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i%5];
      // rho + pi: lane (x,y) moves to (y, 2x+3y) after rotation.
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            b[5*((2*x + 3*y) % 5) + y] = rotl8(a[5*y + x], RHO[5*y + x]);
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            a[5*y + x] = b[5*y + x] ^ (~b[5*y + (x+1)%5] & b[5*y + (x+2)%5]);
      a[0] = a[0] ^ rc_in;
      for (int i = 0; i < 25; i++) r[199 - 8*i -: 8] = a[i];
      return r;
   endfunction

   function automatic logic [199:0] load_state(input logic [SEED_W-1:0] v,
                                               input logic              en);
      logic [SEED_W-1:0] sel;
      logic [SEED_W-1:0] ord;
      sel = en ? v : '0;
      ord = sel;
      if (BYTE_SWAP != 0)
         for (int k = 0; k < SEED_W/8; k++) ord[SEED_W-1 - 8*k -: 8] = sel[8*k +: 8];
      return {ord, {(200-SEED_W){1'b0}}};
   endfunction

   assign round_out  = keccak_round(s, round_const(rc));
   assign seed_state = load_state(seed, seed_en);
   assign out_data   = s[199 -: OUT_W];
   assign state_dbg  = state;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state      <= IDLE;
         s          <= '0;
         rc         <= '0;
         block_cnt  <= '0;
         seed_ready <= 1'b1;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (seed_valid) begin
                  s          <= seed_state;
                  rc         <= '0;
                  block_cnt  <= '0;
                  state      <= PERM;
                  seed_ready <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            PERM: begin
               s <= round_out;
               if (rc == LAST_RC) begin
                  rc         <= '0;
                  state      <= HOLD;
                  busy       <= 1'b0;
                  out_valid  <= 1'b1;
                  seed_ready <= 1'b1;
               end else begin
                  rc <= rc + 5'd1;
               end
            end
            HOLD: begin
               // A seed accept outranks a word transfer on the same edge.
               if (seed_valid) begin
                  s          <= seed_state;
                  rc         <= '0;
                  block_cnt  <= '0;
                  state      <= PERM;
                  out_valid  <= 1'b0;
                  seed_ready <= 1'b0;
                  busy       <= 1'b1;
               end else if (out_ready) begin
                  if (block_cnt != 16'hFFFF) block_cnt <= block_cnt + 16'd1;
                  rc         <= '0;
                  state      <= PERM;
                  out_valid  <= 1'b0;
                  seed_ready <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               rc         <= '0;
               seed_ready <= 1'b1;
               out_valid  <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/prng_stream.md
# prng_stream

Parametrised Keccak-f[200] pseudo-random stream generator for the ROLLO encrypt datapath. A seed is loaded into a 200-bit sponge state, permuted by an in-block round-iterative Keccak-f[200] core (one round per cycle), and squeezed as a sequence of OUT_W-bit words over a valid/ready handshake. Successive words come from re-permuting the full state, so any number of words can be drawn per seed. It replaces the single-shot 96-bit generator wherever an error vector or mask needs more than one block of randomness.

## Interface
- SEED_W, 96: seed width in bits; a multiple of 8, range 8..192.
- OUT_W, 96: output word width; range 1..200.
- NROUNDS, 18: permutation rounds per squeeze; range 1..18, using round constants RC[0..NROUNDS-1].
- BYTE_SWAP, 1: 1 = reverse seed byte order on load (seed byte 0, bits [7:0], lands in state bits [199:192]); 0 = load as given.

- clk  in  1  clock; all state changes on the rising edge.
- rst_b  in  1  asynchronous active-low reset.
- seed_valid  in  1  seed offered.
- seed_ready  out  1  seed can be accepted this cycle.
- seed  in  SEED_W  seed value.
- seed_en  in  1  1 = use seed; 0 = load an all-zero seed.
- out_valid  out  1  out_data holds a fresh word.
- out_ready  in  1  consumer takes out_data.
- out_data  out  OUT_W  state[199 -: OUT_W].
- busy  out  1  permutation running.
- block_cnt  out  16  words delivered since the last seed load.

## Operation
- State S is 200 bits. Lane i = 5y+x is S[199-8i -: 8]; lane bit z is bit z of that byte. Standard theta, rho (Keccak offsets mod 8), pi, chi and iota steps. 8-bit RC[0..17] = 01 82 8A 00 8B 01 81 09 8A 88 09 0A 8B 8B 89 03 02 80.
- Load: S <= {seed', (200-SEED_W)'b0}, where seed' = (seed_en ? seed : 0), byte-reversed if BYTE_SWAP.
- FSM states: IDLE, PERM (round counter rc = 0..NROUNDS-1), HOLD.
- IDLE: seed_ready=1. On seed accept: load S, rc<=0, go to PERM.
- PERM: seed_ready=0 and busy=1. Each edge applies round rc and increments rc. On the edge applying round NROUNDS-1, go to HOLD.
- HOLD: out_valid=1 and seed_ready=1. S is frozen.
  - Handshake (out_valid & out_ready): block_cnt++, saturating at FFFF; rc<=0; go to PERM with the current S (no re-absorb).
  - Seed accept: reload S, block_cnt<=0, go to PERM.
  - Both on the same edge: the word counts as delivered, then the seed load wins; S is reloaded and block_cnt<=0.
- seed_valid during PERM is ignored (no accept). out_ready outside HOLD is ignored.
- Seed accept from IDLE also clears block_cnt.

## Timing
- Reset (asynchronous, immediate, no clock needed):
  - FSM to IDLE, S=0, rc=0, block_cnt=0.
  - Outputs: out_valid=0, busy=0, seed_ready=1, out_data=0.
- Accept at edge T: rounds execute on edges T+1..T+NROUNDS. out_valid=1 in the cycle after edge T+NROUNDS, which is NROUNDS+1 cycles after the accept cycle.
- Handshake at edge H: out_valid=0 for cycles H+1..H+NROUNDS, then high again.
- Throughput with out_ready held at 1: one word per NROUNDS+1 cycles.
- Under backpressure, out_data and block_cnt stay stable while out_valid=1 and out_ready=0.
- Reset asserted mid-PERM aborts the permutation. No word is produced and no partial state persists.

## Test plan
- Reset: drive rst_b=0 with no clock -> out_valid=0, busy=0, seed_ready=1, out_data=0, block_cnt=0.
- Default parameters, seed=96'h0B0A09080706050403020100, seed_en=1, out_ready=1:
  - out_valid first rises 19 cycles after the accept cycle; out_data = top 96 bits of golden Keccak-f[200](S_init).
  - The next word follows 19 cycles later and equals the top 96 bits of f(f(S_init)); block_cnt reads 1, then 2.
- seed_en=0 with arbitrary seed -> first word equals the top 96 bits of golden f(0); BYTE_SWAP=0 gives the same value.
- Backpressure: hold out_ready=0 for 50 cycles in HOLD -> out_valid=1, out_data and block_cnt unchanged; out_ready=1 -> exactly one handshake.
- Reseed:
  - seed_valid during PERM -> no accept and word unchanged.
  - Seed and out_ready together in HOLD -> block_cnt=0; the next word matches the golden model for the new seed.
- Async reset at PERM rc=7 -> all outputs at reset values within the same cycle. A new seed afterwards gives the correct first word.
